// File: rtl/ub_pkg.sv
// Shared widths and read-FSM state type for the unified-buffer activation reader.
package ub_pkg;
  localparam int UB_ADDR_W = 6;
  localparam int UB_DATA_W = 32;
  localparam int UB_LEN_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } ub_rd_state_t;
endpackage

// File: rtl/skew_delay.sv
// One-stage data+valid delay giving lane1 its diagonal offset into the array.
// Only present in builds that define UB_READER_SKEW_EN.
`ifdef UB_READER_SKEW_EN
module skew_delay #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] data_i,
  input  logic         valid_i,
  output logic [W-1:0] data_o,
  output logic         valid_o
);
  logic [W-1:0] data_q;
  logic         valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= valid_i ? data_i : '0;
      valid_q <= valid_i;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
endmodule
`endif

// File: rtl/ub_reader.sv
// Streams len two-word activation vectors from the unified buffer into systolic rows 0/1.
// Define UB_READER_SKEW_EN to delay lane1 by one cycle (diagonal feed).
module ub_reader
  import ub_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [UB_ADDR_W-1:0] base_addr,
  input  logic [UB_LEN_W-1:0]  len,
  output logic                 rd_en,
  output logic [UB_ADDR_W-1:0] rd_addr0,
  output logic [UB_ADDR_W-1:0] rd_addr1,
  input  logic [UB_DATA_W-1:0] rd_data0,
  input  logic [UB_DATA_W-1:0] rd_data1,
  output logic [UB_DATA_W-1:0] a0_out,
  output logic [UB_DATA_W-1:0] a1_out,
  output logic                 a0_valid,
  output logic                 a1_valid,
  output logic                 busy,
  output logic                 done
);
  ub_rd_state_t         state_q, state_d;
  logic [UB_LEN_W-1:0]  k_q, k_d;
  logic [UB_LEN_W-1:0]  len_q, len_d;
  logic [UB_ADDR_W-1:0] base_q, base_d;
  logic                 done_q, done_d;
  logic                 rdv_q;
  logic [UB_DATA_W-1:0] a0_q, l1_q;
  logic                 a0v_q, l1v_q;
  logic                 pending;
  logic [UB_ADDR_W-1:0] addr_even;

  assign addr_even = base_q + {k_q, 1'b0};
  assign rd_en     = (state_q == READ);
  assign rd_addr0  = rd_en ? addr_even : '0;
  assign rd_addr1  = rd_en ? addr_even + 6'd1 : '0;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign a0_out    = a0_q;
  assign a0_valid  = a0v_q;

`ifdef UB_READER_SKEW_EN
  skew_delay #(.W(UB_DATA_W)) u_skew (
    .clk     (clk),
    .rst_n   (reset),
    .data_i  (l1_q),
    .valid_i (l1v_q),
    .data_o  (a1_out),
    .valid_o (a1_valid)
  );
  assign pending = rdv_q | l1v_q;
`else
  assign a1_out   = l1_q;
  assign a1_valid = l1v_q;
  assign pending  = rdv_q;
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    len_d   = len_q;
    base_d  = base_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            base_d  = base_addr;
            len_d   = len;
            k_d     = '0;
            state_d = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        k_d = k_q + 5'd1;
        if (k_q == len_q - 5'd1) state_d = DRAIN;
      end
      DRAIN: begin
        // The final lane1 beat is on the output and nothing is left upstream.
        if (a1_valid && !pending) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      len_q   <= '0;
      base_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      len_q   <= len_d;
      base_q  <= base_d;
      done_q  <= done_d;
    end
  end

  // Read data arrives the cycle after rd_en; capture it zero-gated when not valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdv_q <= 1'b0;
      a0_q  <= '0;
      a0v_q <= 1'b0;
      l1_q  <= '0;
      l1v_q <= 1'b0;
    end else begin
      rdv_q <= rd_en;
      a0_q  <= rdv_q ? rd_data0 : '0;
      a0v_q <= rdv_q;
      l1_q  <= rdv_q ? rd_data1 : '0;
      l1v_q <= rdv_q;
    end
  end
endmodule

// File: tb/tb_ub_reader.sv
// Directed self-checking bench for ub_reader; expected timing follows UB_READER_SKEW_EN.
module tb_ub_reader;
`ifdef UB_READER_SKEW_EN
  localparam int SKEW = 1;
`else
  localparam int SKEW = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  base_addr;
  logic [4:0]  len;
  logic        rd_en;
  logic [5:0]  rd_addr0, rd_addr1;
  logic [31:0] rd_data0, rd_data1;
  logic [31:0] a0_out, a1_out;
  logic        a0_valid, a1_valid, busy, done;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [64];

  logic        tRden [40];
  logic [5:0]  tAd0  [40];
  logic [5:0]  tAd1  [40];
  logic        tA0v  [40];
  logic        tA1v  [40];
  logic [31:0] tA0   [40];
  logic [31:0] tA1   [40];
  logic        tBusy [40];
  logic        tDone [40];

  ub_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .rd_en     (rd_en),
    .rd_addr0  (rd_addr0),
    .rd_addr1  (rd_addr1),
    .rd_data0  (rd_data0),
    .rd_data1  (rd_data1),
    .a0_out    (a0_out),
    .a1_out    (a1_out),
    .a0_valid  (a0_valid),
    .a1_valid  (a1_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_data0 <= rd_en ? mem[rd_addr0] : 32'hDEADBEEF;
    rd_data1 <= rd_en ? mem[rd_addr1] : 32'hDEADBEEF;
  end

  task automatic runTrace(input logic [5:0] b, input logic [4:0] l, input int ncyc,
                          input int restartCyc, input logic [5:0] rb, input logic [4:0] rl,
                          input int resetCyc);
    @(negedge clk);
    start = 1'b1; base_addr = b; len = l;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start = 1'b0;
      reset = 1'b1;
      if (c == resetCyc) reset = 1'b0;
      if (c == restartCyc) begin start = 1'b1; base_addr = rb; len = rl; end
      #1;
      tRden[c] = rd_en; tAd0[c] = rd_addr0; tAd1[c] = rd_addr1;
      tA0v[c] = a0_valid; tA1v[c] = a1_valid; tA0[c] = a0_out; tA1[c] = a1_out;
      tBusy[c] = busy; tDone[c] = done;
    end
    start = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] got;
    got = {rd_en, rd_addr0, rd_addr1, a0_valid, a1_valid, busy, done};
    checks++;
    if (got !== 32'd0) begin errors++; $display("[TB] FAIL reset_ctrl got %h want 0", got); end
    checks++;
    if (a0_out !== 32'd0) begin errors++; $display("[TB] FAIL reset_a0 got %h want 0", a0_out); end
    checks++;
    if (a1_out !== 32'd0) begin errors++; $display("[TB] FAIL reset_a1 got %h want 0", a1_out); end
  endtask

  task automatic test_basic(input string tag);
    int doneC;
    logic        ev0, ev1;
    logic [31:0] e0, e1;
    doneC = 5 + SKEW;
    runTrace(6'h1E, 5'd2, 10, -1, 6'h0, 5'd0, -1);
    checks++;
    if ({tAd0[1], tAd1[1], tAd0[2], tAd1[2]} !== {6'h1E, 6'h1F, 6'h20, 6'h21}) begin
      errors++;
      $display("[TB] FAIL %s_addr got %h %h %h %h want 1e 1f 20 21", tag, tAd0[1], tAd1[1], tAd0[2], tAd1[2]);
    end
    for (int c = 1; c <= 10; c++) begin
      ev0 = (c == 3) || (c == 4);
      e0  = (c == 3) ? 32'd11 : (c == 4) ? 32'd21 : 32'd0;
      ev1 = (c == 3 + SKEW) || (c == 4 + SKEW);
      e1  = (c == 3 + SKEW) ? 32'd12 : (c == 4 + SKEW) ? 32'd22 : 32'd0;
      checks++;
      if ({tRden[c], tBusy[c], tDone[c]} !== {c <= 2, c < doneC, c == doneC}) begin
        errors++;
        $display("[TB] FAIL %s_ctrl c%0d got rd_en/busy/done %b%b%b want %b%b%b", tag, c,
                 tRden[c], tBusy[c], tDone[c], c <= 2, c < doneC, c == doneC);
      end
      checks++;
      if (tA0v[c] !== ev0 || tA0[c] !== e0) begin
        errors++;
        $display("[TB] FAIL %s_a0 c%0d got %b/%0d want %b/%0d", tag, c, tA0v[c], tA0[c], ev0, e0);
      end
      checks++;
      if (tA1v[c] !== ev1 || tA1[c] !== e1) begin
        errors++;
        $display("[TB] FAIL %s_a1 c%0d got %b/%0d want %b/%0d", tag, c, tA1v[c], tA1[c], ev1, e1);
      end
    end
  endtask

  task automatic test_len0;
    runTrace(6'h05, 5'd0, 6, -1, 6'h0, 5'd0, -1);
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if ({tRden[c], tBusy[c], tDone[c], tA0v[c], tA1v[c]} !== {3'b00, c == 1, 2'b00}) begin
        errors++;
        $display("[TB] FAIL len0 c%0d got rd_en/busy/done/v0/v1 %b%b%b%b%b want 00%b00", c,
                 tRden[c], tBusy[c], tDone[c], tA0v[c], tA1v[c], c == 1);
      end
    end
  endtask

  task automatic test_wrap;
    runTrace(6'h3E, 5'd2, 8, -1, 6'h0, 5'd0, -1);
    checks++;
    if ({tAd0[1], tAd1[1]} !== {6'h3E, 6'h3F}) begin
      errors++; $display("[TB] FAIL wrap_pair0 got %h %h want 3e 3f", tAd0[1], tAd1[1]);
    end
    checks++;
    if ({tAd0[2], tAd1[2]} !== {6'h00, 6'h01}) begin
      errors++; $display("[TB] FAIL wrap_pair1 got %h %h want 00 01", tAd0[2], tAd1[2]);
    end
    checks++;
    if (tA0[3] !== 32'hA000003E || tA0[4] !== 32'd0 + 32'hA0000000) begin
      errors++; $display("[TB] FAIL wrap_a0 got %h %h want a000003e a0000000", tA0[3], tA0[4]);
    end
    checks++;
    if (tA1[3 + SKEW] !== 32'hA000003F || tA1[4 + SKEW] !== 32'hA0000001) begin
      errors++; $display("[TB] FAIL wrap_a1 got %h %h want a000003f a0000001", tA1[3 + SKEW], tA1[4 + SKEW]);
    end
  endtask

  task automatic test_ignore_start;
    int nRd, nDone;
    nRd = 0; nDone = 0;
    runTrace(6'h10, 5'd3, 14, 2, 6'h30, 5'd5, -1);
    for (int c = 1; c <= 14; c++) begin
      nRd   += int'(tRden[c]);
      nDone += int'(tDone[c]);
    end
    checks++;
    if (nRd != 3) begin errors++; $display("[TB] FAIL ignore_rdcount got %0d want 3", nRd); end
    checks++;
    if (nDone != 1 || tDone[6 + SKEW] !== 1'b1) begin
      errors++; $display("[TB] FAIL ignore_done got count %0d at_c%0d=%b want 1 and 1", nDone, 6 + SKEW, tDone[6 + SKEW]);
    end
    checks++;
    if ({tAd0[1], tAd0[2], tAd0[3]} !== {6'h10, 6'h12, 6'h14}) begin
      errors++; $display("[TB] FAIL ignore_addr got %h %h %h want 10 12 14", tAd0[1], tAd0[2], tAd0[3]);
    end
    checks++;
    if (tA0[5] !== 32'hA0000014) begin
      errors++; $display("[TB] FAIL ignore_a0last got %h want a0000014", tA0[5]);
    end
  endtask

  task automatic test_reset_mid;
    int nAct;
    nAct = 0;
    runTrace(6'h00, 5'd4, 12, -1, 6'h0, 5'd0, 2);
    checks++;
    if ({tRden[2], tAd0[2], tAd1[2], tA0v[2], tA1v[2], tBusy[2], tDone[2]} !== 17'd0 || tA0[2] !== 32'd0 || tA1[2] !== 32'd0) begin
      errors++; $display("[TB] FAIL rstmid_immediate got rd_en %b addr %h/%h busy %b", tRden[2], tAd0[2], tAd1[2], tBusy[2]);
    end
    for (int c = 2; c <= 12; c++) nAct += int'(tRden[c]) + int'(tA0v[c]) + int'(tA1v[c]) + int'(tDone[c]);
    checks++;
    if (nAct != 0) begin errors++; $display("[TB] FAIL rstmid_quiet got %0d active beats want 0", nAct); end
    test_basic("fresh");
  endtask

  task automatic test_back_to_back;
    int d;
    d = 4 + SKEW;
    runTrace(6'h1E, 5'd1, 14, d, 6'h20, 5'd1, -1);
    checks++;
    if (tDone[d] !== 1'b1 || tRden[d] !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_done1 got done %b rd_en %b want 1 0", tDone[d], tRden[d]);
    end
    checks++;
    if (tRden[d + 1] !== 1'b1 || tAd0[d + 1] !== 6'h20) begin
      errors++; $display("[TB] FAIL b2b_restart got rd_en %b addr %h want 1 20", tRden[d + 1], tAd0[d + 1]);
    end
    checks++;
    if (tA0[d + 3] !== 32'd21 || tDone[2 * d] !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_second got a0 %0d done %b want 21 1", tA0[d + 3], tDone[2 * d]);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA0000000 + i;
    mem[6'h1E] = 32'd11; mem[6'h1F] = 32'd12; mem[6'h20] = 32'd21; mem[6'h21] = 32'd22;
    reset = 1'b0; start = 1'b0; base_addr = '0; len = '0;
    repeat (3) @(negedge clk);
    test_reset;
    reset = 1'b1;
    test_basic("basic");
    test_len0;
    test_wrap;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ub_reader.md
UB_READER -- requirements
Module: ub_reader

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1: single-cycle request; sampled only in IDLE.
REQ-004 SHALL have port base_addr, input, 6: first word address, latched on accepted start.
REQ-005 SHALL have port len, input, 5: number of 2-word activation vectors, latched on accepted start.
REQ-006 SHALL have port rd_en, output, 1: read strobe to unified buffer, both ports.
REQ-007 SHALL have ports rd_addr0 and rd_addr1, output, 6 each: lane0 and lane1 word addresses.
REQ-008 SHALL have ports rd_data0 and rd_data1, input, 32 each: read data, valid the cycle after rd_en.
REQ-009 SHALL have ports a0_out and a1_out, output, 32 each: activation into systolic rows 0 and 1.
REQ-010 SHALL have ports a0_valid and a1_valid, output, 1 each: qualify a0_out and a1_out.
REQ-011 SHALL have port busy, output, 1: high from the cycle after an accepted start until done.
REQ-012 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-013 SHALL implement an FSM with states IDLE, READ and DRAIN.
REQ-014 IDLE with start=1 and len>0 SHALL latch base_addr and len, go to READ, and clear vector counter k.
REQ-015 IDLE with start=1 and len=0 SHALL pulse done next cycle, issue no reads, and stay IDLE.
REQ-016 start while busy SHALL be ignored, with no effect on state, latched values or outputs.
REQ-017 READ SHALL drive rd_en=1, rd_addr0=base+2k and rd_addr1=base+2k+1 (mod 64), incrementing k each cycle.
REQ-018 READ SHALL go to DRAIN after issuing vector k=len-1, giving exactly len consecutive rd_en cycles.
REQ-019 Address arithmetic SHALL wrap modulo 64, e.g. base 0x3F gives rd_addr1 0x00 for k=0.
REQ-020 a0_out SHALL register rd_data0, with a0_valid high two cycles after the matching rd_en.
REQ-021 a1_out SHALL register rd_data1 with the skew defined in REQ-031/032.
REQ-022 a0_out and a1_out SHALL be 0 whenever their valid is low.
REQ-023 DRAIN SHALL pulse done in the cycle after the last a1_valid, drop busy in that same cycle, and return to IDLE.
REQ-024 Timing SHALL be, for start sampled at end of cycle 0 with skew enabled: rd_en cycles 1..L, a0_valid cycles 3..L+2, a1_valid cycles 4..L+3, done cycle L+4.
REQ-025 A start in the done cycle SHALL be accepted, since the FSM is already IDLE.

Reset
REQ-026 reset low SHALL immediately force IDLE, k=0 and latched regs 0.
REQ-027 reset low SHALL immediately force rd_en, rd_addr*, a*_out, a*_valid, busy and done to 0.
REQ-028 Reset mid-transfer SHALL abort with no done pulse and no further valid beats.
REQ-029 After reset deassertion the block SHALL accept start on the first rising edge.

Configuration
REQ-030 Macro UB_READER_SKEW_EN SHALL select lane1 skew.
REQ-031 With UB_READER_SKEW_EN defined, lane1 SHALL be delayed one extra cycle relative to lane0, giving diagonal feed.
REQ-032 Without UB_READER_SKEW_EN, a1_valid SHALL equal a0_valid timing and done SHALL occur at cycle L+3.

Structure
REQ-033 Package ub_pkg SHALL hold UB_ADDR_W=6, UB_DATA_W=32 and UB_LEN_W=5, plus the state enum ub_rd_state_t.
REQ-034 Lane1 skew SHALL be a sub-module skew_delay: one-stage data+valid register with async active-low reset, instantiated only under UB_READER_SKEW_EN.

Verification
REQ-035 Memory holds 0x1E=11, 0x1F=12, 0x20=21, 0x21=22; start base=0x1E, len=2 -> a0: 11@c3, 21@c4; a1: 12@c4, 22@c5; done@c6.
REQ-036 Bench SHALL cover: len=0 -> done@c1, rd_en never asserted, busy stays 0.
REQ-037 Bench SHALL cover: base=0x3E, len=2 -> rd_addr pairs (0x3E,0x3F) then (0x00,0x01).
REQ-038 Bench SHALL cover: start pulsed again at c2 of a len=3 transfer -> ignored, exactly 3 rd_en cycles, one done.
REQ-039 Bench SHALL cover: reset low at c2 of a len=4 transfer -> all outputs 0 at once, no done, next start behaves as fresh.
REQ-040 Bench SHALL cover: build without UB_READER_SKEW_EN, the REQ-035 stimulus -> a0/a1 both valid c3..c4 (11/12, 21/22), done@c5.
